// File: rtl/seg_display_scanner_pkg.sv
// Shared constants, scan state type and digit helpers for the 4-digit display scanner.
package seg_disp_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    typedef enum logic {
        BLANK  = 1'b0,
        ACTIVE = 1'b1
    } scan_state_e;

    // Nibble of a 16-bit display word belonging to digit position idx.
    function automatic logic [3:0] nibble_at(input logic [15:0] val, input logic [1:0] idx);
        return val[4*idx +: 4];
    endfunction

    // Active-low anode pattern selecting digit position idx.
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // True when digit idx is a leading zero: it and every higher nibble are zero.
    // Digit 0 is never suppressed.
    function automatic logic is_leading_zero(input logic [15:0] val, input logic [1:0] idx);
        case (idx)
            2'd1:    return (val[15:4]  == 12'h000);
            2'd2:    return (val[15:8]  == 8'h00);
            2'd3:    return (val[15:12] == 4'h0);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seg_display_scanner_if.sv
// Control/data bundle between the display scanner and its host.
interface seg_display_scanner_if;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic [3:0]  digit;
    logic [3:0]  anode;
    logic        dp_n;
    logic        frame_done;

    modport master (
        output enable, load, value, dp_mask, lz_blank,
        input  digit, anode, dp_n, frame_done
    );

    modport slave (
        input  enable, load, value, dp_mask, lz_blank,
        output digit, anode, dp_n, frame_done
    );
endinterface

// File: rtl/seg_scan_timer.sv
// Terminal-count counter shared by the BLANK and ACTIVE phases; wraps to zero on tc.
module seg_scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] count_q;

    assign tc = (count_q == tc_val);

    // Count up to the selected terminal value, restarting on tc or explicit clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else if (clr || tc)
            count_q <= '0;
        else
            count_q <= count_q + W'(1);
    end

endmodule

// File: rtl/seg_display_scanner.sv
// Four-digit multiplexed seven-segment scanner with blanking gaps,
// leading-zero suppression and frame-synchronous double-buffered loads.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   BLANK  | all anodes off for BLANK_CYCLES between digits
//   ACTIVE | digit idx lit for REFRESH_CYCLES (anode off if leading zero)
module seg_display_scanner
    import seg_disp_pkg::*;
#(
    parameter int REFRESH_CYCLES = 100000,
    parameter int BLANK_CYCLES   = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seg_display_scanner_if.slave  bus
);

    localparam int MAX_CYCLES = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);
    localparam logic [CW-1:0] REF_TC = CW'(REFRESH_CYCLES - 1);
    localparam logic [CW-1:0] BLK_TC = CW'(BLANK_CYCLES - 1);

    scan_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  anode_q, anode_d;
    logic [3:0]  digit_q, digit_d;
    logic        dp_n_q, dp_n_d;
    logic        frame_done_q, frame_done_d;

    logic [15:0] shown_q, pending_q, shown_next;
    logic [3:0]  shown_dp_q, pend_dp_q, shown_dp_next;
    logic        pend_flag_q;
    logic        commit;
    logic        tc;

    seg_scan_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!bus.enable),
        .tc_val ((state_q == ACTIVE) ? REF_TC : BLK_TC),
        .tc     (tc)
    );

    // A pending word only becomes visible at the start of digit 0, so a frame never mixes two loads.
    assign commit        = bus.enable && (state_q == BLANK) && tc && (idx_q == 2'd0) && pend_flag_q;
    assign shown_next    = commit ? pending_q : shown_q;
    assign shown_dp_next = commit ? pend_dp_q : shown_dp_q;

    // Scan state and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= BLANK;
            idx_q        <= 2'd0;
            anode_q      <= ANODE_OFF;
            digit_q      <= 4'h0;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            digit_q      <= digit_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state and next-output decode; digit/dp change only when a digit is about to light.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        anode_d      = anode_q;
        digit_d      = digit_q;
        dp_n_d       = dp_n_q;
        frame_done_d = 1'b0;
        if (!bus.enable) begin
            state_d = BLANK;
            idx_d   = 2'd0;
            anode_d = ANODE_OFF;
        end else begin
            case (state_q)
                BLANK: begin
                    if (tc) begin
                        state_d = ACTIVE;
                        digit_d = nibble_at(shown_next, idx_q);
                        dp_n_d  = ~shown_dp_next[idx_q];
                        anode_d = (bus.lz_blank && is_leading_zero(shown_next, idx_q))
                                  ? ANODE_OFF : anode_for(idx_q);
                    end
                end
                ACTIVE: begin
                    if (tc) begin
                        state_d      = BLANK;
                        idx_d        = idx_q + 2'd1;
                        anode_d      = ANODE_OFF;
                        frame_done_d = (idx_q == 2'd3);
                    end
                end
                default: begin
                    state_d = BLANK;
                    anode_d = ANODE_OFF;
                end
            endcase
        end
    end

    // Double buffer: loads land in pending; commit moves pending to shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= 16'h0000;
            pend_dp_q   <= 4'h0;
            pend_flag_q <= 1'b0;
            shown_q     <= 16'h0000;
            shown_dp_q  <= 4'h0;
        end else begin
            if (commit) begin
                shown_q    <= pending_q;
                shown_dp_q <= pend_dp_q;
            end
            if (bus.load) begin
                pending_q   <= bus.value;
                pend_dp_q   <= bus.dp_mask;
                pend_flag_q <= 1'b1;
            end else if (commit) begin
                pend_flag_q <= 1'b0;
            end
        end
    end

    assign bus.digit      = digit_q;
    assign bus.anode      = anode_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for the display scanner with REFRESH_CYCLES=8, BLANK_CYCLES=2.
// cyc counts clock edges since the last reset release; digit k of a frame lights at cyc 2+10k.
module tb_seg_display_scanner;

    localparam int RC = 8;
    localparam int BC = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   fd_cnt = 0;

    seg_display_scanner_if bus ();

    seg_display_scanner #(
        .REFRESH_CYCLES (RC),
        .BLANK_CYCLES   (BC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.frame_done) fd_cnt++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Present a load for exactly one edge.
    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        bus.load    = 1'b1;
        bus.value   = v;
        bus.dp_mask = dp;
        tick();
        bus.load    = 1'b0;
    endtask

    task automatic chk_lit(input string tag, input logic [3:0] an, input logic [3:0] dg);
        chk({tag, "_anode"}, bus.anode, an);
        chk({tag, "_digit"}, bus.digit, dg);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_anode"}, bus.anode, 4'b1111);
        chk({tag, "_digit"}, bus.digit, 4'h0);
        chk({tag, "_dp_n"},  4'(bus.dp_n), 4'h1);
        chk({tag, "_fdone"}, 4'(bus.frame_done), 4'h0);
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.value    = 16'h0000;
        bus.dp_mask  = 4'h0;
        bus.lz_blank = 1'b0;
        #12;
        chk_reset("rst");

        // 1: basic scan of 1234, load presented on the first edge after release
        bus.enable = 1'b1;
        bus.load   = 1'b1;
        bus.value  = 16'h1234;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cyc    = 0;
        fd_cnt = 0;
        tick();
        bus.load = 1'b0;
        chk("t1_dark", bus.anode, 4'b1111);
        run_to(2);  chk_lit("t1_d0", 4'b1110, 4'h4);
        run_to(9);  chk("t1_d0_end", bus.anode, 4'b1110);
        run_to(10); chk("t1_gap", bus.anode, 4'b1111);
        chk("t1_gap_fd", 4'(bus.frame_done), 4'h0);
        run_to(12); chk_lit("t1_d1", 4'b1101, 4'h3);
        run_to(22); chk_lit("t1_d2", 4'b1011, 4'h2);
        run_to(32); chk_lit("t1_d3", 4'b0111, 4'h1);
        run_to(40); chk("t1_fd", 4'(bus.frame_done), 4'h1);
        run_to(41); chk("t1_fd_off", 4'(bus.frame_done), 4'h0);

        // 2: load ABCD while digit 2 is lit; rest of frame stays 1234
        run_to(63); do_load(16'hABCD, 4'h0);
        run_to(72); chk_lit("t2_d3_old", 4'b0111, 4'h1);
        run_to(80); chk("t2_fd_cnt", 4'(fd_cnt), 4'h2);
        run_to(82); chk_lit("t2_d0", 4'b1110, 4'hD);
        run_to(92); chk_lit("t2_d1", 4'b1101, 4'hC);
        run_to(102); chk_lit("t2_d2", 4'b1011, 4'hB);
        run_to(112); chk_lit("t2_d3", 4'b0111, 4'hA);

        // 3: leading-zero blanking
        run_to(113);
        bus.lz_blank = 1'b1;
        do_load(16'h0070, 4'h0);
        run_to(122); chk_lit("t3_d0", 4'b1110, 4'h0);
        run_to(132); chk_lit("t3_d1", 4'b1101, 4'h7);
        run_to(142); chk("t3_d2_blank", bus.anode, 4'b1111);
        run_to(145); chk("t3_d2_blank_mid", bus.anode, 4'b1111);
        run_to(152); chk("t3_d3_blank", bus.anode, 4'b1111);
        run_to(153); do_load(16'h0000, 4'h0);
        run_to(162); chk_lit("t3z_d0", 4'b1110, 4'h0);
        run_to(172); chk("t3z_d1", bus.anode, 4'b1111);
        run_to(182); chk("t3z_d2", bus.anode, 4'b1111);
        run_to(192); chk("t3z_d3", bus.anode, 4'b1111);

        // 4: decimal point on digit 2 only
        run_to(193);
        bus.lz_blank = 1'b0;
        do_load(16'h5678, 4'b0100);
        run_to(202); chk_lit("t4_d0", 4'b1110, 4'h8); chk("t4_d0_dp", 4'(bus.dp_n), 4'h1);
        run_to(212); chk_lit("t4_d1", 4'b1101, 4'h7); chk("t4_d1_dp", 4'(bus.dp_n), 4'h1);
        run_to(222); chk_lit("t4_d2", 4'b1011, 4'h6); chk("t4_d2_dp", 4'(bus.dp_n), 4'h0);
        run_to(229); chk("t4_d2_dp_end", 4'(bus.dp_n), 4'h0);
        run_to(232); chk_lit("t4_d3", 4'b0111, 4'h5); chk("t4_d3_dp", 4'(bus.dp_n), 4'h1);

        // 5: last load wins; load on the commit edge is deferred a frame
        run_to(234);
        do_load(16'h1111, 4'h0);
        do_load(16'h2222, 4'h0);
        run_to(242); chk_lit("t5_d0", 4'b1110, 4'h2);
        run_to(252); chk("t5_d1", bus.digit, 4'h2);
        run_to(262); chk("t5_d2", bus.digit, 4'h2);
        run_to(272); chk("t5_d3", bus.digit, 4'h2);
        run_to(274); do_load(16'h3333, 4'h0);
        run_to(281); do_load(16'h4444, 4'h0);
        chk_lit("t5_commit", 4'b1110, 4'h3);
        run_to(312); chk("t5_commit_d3", bus.digit, 4'h3);
        run_to(322); chk_lit("t5_defer", 4'b1110, 4'h4);
        run_to(352); chk("t5_defer_d3", bus.digit, 4'h4);

        // 6a: reset pulse during ACTIVE drops pending load
        run_to(353); do_load(16'h5555, 4'hF);
        run_to(355); chk("t6_pre", bus.anode, 4'b0111);
        rst_n = 1'b0;
        #1;
        chk_reset("t6_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        tick();     chk("t6_dark", bus.anode, 4'b1111);
        tick();     chk_lit("t6_first", 4'b1110, 4'h0);
        chk("t6_first_dp", 4'(bus.dp_n), 4'h1);
        run_to(4);  do_load(16'h9876, 4'h0);
        run_to(12); chk_lit("t6_d1", 4'b1101, 4'h0);
        run_to(42); chk_lit("t6_new", 4'b1110, 4'h6);

        // 6b: disable for 3 cycles with a load while dark
        run_to(45);
        bus.enable = 1'b0;
        tick();     chk("t6_off", bus.anode, 4'b1111);
        chk("t6_off_fd", 4'(bus.frame_done), 4'h0);
        do_load(16'hABCD, 4'h0);
        chk("t6_off2", bus.anode, 4'b1111);
        tick();     chk("t6_off3", bus.anode, 4'b1111);
        bus.enable = 1'b1;
        tick();     chk("t6_resume_dark", bus.anode, 4'b1111);
        tick();     chk_lit("t6_resume", 4'b1110, 4'hD);
        run_to(60); chk_lit("t6_resume_d1", 4'b1101, 4'hC);

        // 6c: disable again without a load; shown value preserved
        run_to(62);
        bus.enable = 1'b0;
        run_to(65); chk("t6c_off", bus.anode, 4'b1111);
        bus.enable = 1'b1;
        tick();     chk("t6c_dark", bus.anode, 4'b1111);
        tick();     chk_lit("t6c_resume", 4'b1110, 4'hD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
